fw_loc_sampler: RTL and testbench
=================================

FW_LOC_SAMPLER -- requirements
Module: fw_loc_sampler

Interface
REQ-001 SHALL have parameter N, default 17669, vector length; valid locations are 0..N-1.
REQ-002 SHALL have parameter M, default 15, location width in bits (2^M >= N).
REQ-003 SHALL have parameter WEIGHT, default 75, number of distinct locations per vector.
REQ-004 SHALL have parameter LOG_WEIGHT, default `CLOG2(WEIGHT), read-address width.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse; begin a new vector.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse; WEIGHT distinct locations stored.
REQ-010 SHALL have port rnd_valid  input  1  random word from the SHAKE output stream is valid.
REQ-011 SHALL have port rnd_ready  output  1  sampler accepts rnd_data this cycle.
REQ-012 SHALL have port rnd_data  input  32  random word; bits [23:0] used, [31:24] ignored.
REQ-013 SHALL have port rnd_stop  output  1  one-cycle pulse to the SHAKE force_done input.
REQ-014 SHALL have port rd_en  input  1  location read strobe.
REQ-015 SHALL have port rd_addr  input  LOG_WEIGHT  location index.
REQ-016 SHALL have port rd_loc  output  M  registered read data.

Function
REQ-017 SHALL compute THRESH = floor(2^24 / N) * N at elaboration (N=17669: 16767881, 0xFFDB89).
REQ-018 SHALL implement states IDLE, FETCH, REDUCE, CHECK, DONE.
REQ-019 IDLE: start=1 -> clear entry count cnt to 0, go FETCH; start is ignored in all other states.
REQ-020 FETCH: rnd_ready=1; on rnd_valid&rnd_ready, cand=rnd_data[23:0]; cand>=THRESH -> discard, stay FETCH; else go REDUCE.
REQ-021 REDUCE: register loc = cand mod N (M bits); always one cycle; go CHECK.
REQ-022 CHECK: compare loc in parallel with entries 0..cnt-1 only; match -> discard, go FETCH; no match -> write entry[cnt]=loc, cnt+1.
REQ-023 CHECK with no match: if the new cnt equals WEIGHT go DONE, else go FETCH.
REQ-024 DONE: done=1 and rnd_stop=1 for exactly this one cycle; busy=0 in it; next state IDLE.
REQ-025 rnd_ready SHALL be 0 outside FETCH; a word is consumed only on rnd_valid&rnd_ready.
REQ-026 Minimum cost per accepted unique word: 3 cycles (FETCH, REDUCE, CHECK); minimum start-to-done latency 3*WEIGHT+1 cycles.
REQ-027 Entries are stored in flops in acceptance order; entries >= cnt are never compared or relied upon.
REQ-028 Read: rd_en=1 -> rd_loc = entry[rd_addr] on the next cycle; rd_addr >= WEIGHT -> 0; rd_en=0 -> rd_loc holds.
REQ-029 Reads are permitted while busy and return current contents; a CHECK write and a read of the same index in one cycle return the old value.
REQ-030 After done, entries stay valid until the next accepted start; a new start re-fills from index 0.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, cnt=0, busy=0, done=0, rnd_ready=0, rnd_stop=0, rd_loc=0, all entries=0.
REQ-032 Reset mid-operation SHALL abandon the vector; no done or rnd_stop pulse; a start is required afterwards.

Configuration
REQ-033 With macro FW_REJECT_CNT_EN defined, the module SHALL add output rej_cnt (16 bits), cleared on reset and on accepted start, incremented once per threshold or duplicate rejection, saturating at 0xFFFF.
REQ-034 Without FW_REJECT_CNT_EN, the rej_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Reset then WEIGHT=75, N=17669, rnd_valid held 1 with increasing words 0,1,2..74 -> done after exactly 226 cycles, rd_addr k returns k.
REQ-036 WEIGHT=4: words 0x5, 0x00FFFFFF, 0x4505, 0x450A, 0x7, 0x9 -> stored {5,0,7,9}; 0x00FFFFFF threshold-rejected, 0x450A duplicate-rejected; rej_cnt=2 when FW_REJECT_CNT_EN is defined.
REQ-037 Word 0xAB00000C with rnd_valid toggling 1/0 each cycle -> loc 12 accepted; no word consumed while rnd_ready=0 or rnd_valid=0.
REQ-038 Boundary: cand 0xFFDB88 accepted as 16767880 mod 17669 = 17668; cand 0xFFDB89 rejected.
REQ-039 rst_n=0 for one cycle while in CHECK at cnt=40 -> all outputs at reset values; no done; new start yields fresh vector from index 0.
REQ-040 start pulsed while busy -> ignored; cnt is not cleared; single done pulse with rnd_stop in the same cycle.

Source files
------------

// File: rtl/fw_loc_sampler.sv
// Fixed-weight location sampler: draws WEIGHT distinct locations in [0,N) from a
// 24-bit random stream. Optional rejection counter under FW_REJECT_CNT_EN.
module fw_loc_sampler #(
  parameter int N          = 17669,
  parameter int M          = 15,
  parameter int WEIGHT     = 75,
  parameter int LOG_WEIGHT = $clog2(WEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  input  logic [31:0]           rnd_data,
  output logic                  rnd_stop,
  input  logic                  rd_en,
  input  logic [LOG_WEIGHT-1:0] rd_addr,
  output logic [M-1:0]          rd_loc
`ifdef FW_REJECT_CNT_EN
  ,
  output logic [15:0]           rej_cnt
`endif
);

  localparam int          CW     = $clog2(WEIGHT + 1);
  localparam logic [23:0] N24    = 24'(N);
  // largest multiple of N below 2^24; keeps the mod-N reduction unbiased
  localparam logic [23:0] THRESH = 24'(((1 << 24) / N) * N);

  typedef enum logic [2:0] {IDLE, FETCH, REDUCE, CHECK, DONE} state_t;

  state_t                     state, state_nxt;
  logic [23:0]                cand;
  logic [M-1:0]               loc;
  logic [CW-1:0]              cnt;
  logic [WEIGHT-1:0][M-1:0]   entries;
  logic [WEIGHT-1:0]          hit;
  logic                       dup, take, cand_ok;
  logic                       unused_hi;

  assign unused_hi = ^rnd_data[31:24];
  assign take      = rnd_valid && rnd_ready;
  assign cand_ok   = rnd_data[23:0] < THRESH;

  // only the filled prefix of the table takes part in the duplicate search
  for (genvar i = 0; i < WEIGHT; i++) begin : g_cmp
    assign hit[i] = (CW'(i) < cnt) && (entries[i] == loc);
  end
  assign dup = |hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rnd_ready = 1'b0;
    rnd_stop  = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = FETCH;
      FETCH: begin
        busy      = 1'b1;
        rnd_ready = 1'b1;
        if (take && cand_ok) state_nxt = REDUCE;
      end
      REDUCE: begin
        busy      = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (!dup && cnt == CW'(WEIGHT - 1)) state_nxt = DONE;
        else                                state_nxt = FETCH;
      end
      DONE: begin
        done      = 1'b1;
        rnd_stop  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      cand    <= '0;
      loc     <= '0;
      entries <= '0;
    end else begin
      case (state)
        IDLE:   if (start) cnt <= '0;
        FETCH:  if (take) cand <= rnd_data[23:0];
        REDUCE: loc <= M'(cand % N24);
        CHECK: begin
          if (!dup) begin
            for (int i = 0; i < WEIGHT; i++)
              if (CW'(i) == cnt) entries[i] <= loc;
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // out-of-range addresses match no entry and read back as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_loc <= '0;
    end else if (rd_en) begin
      rd_loc <= '0;
      for (int i = 0; i < WEIGHT; i++)
        if (int'(rd_addr) == i) rd_loc <= entries[i];
    end
  end

`ifdef FW_REJECT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rej_cnt <= '0;
    else if (state == IDLE && start)
      rej_cnt <= '0;
    else if (((take && !cand_ok) || (state == CHECK && dup)) && rej_cnt != 16'hFFFF)
      rej_cnt <= rej_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fw_loc_sampler.sv
// Directed bench for fw_loc_sampler: a default-size instance and a WEIGHT=4 instance
// share the random stream; expected locations come from a reference model queue.
module tb_fw_loc_sampler;
  localparam int N   = 17669;
  localparam int WB  = 75;
  localparam int WS  = 4;
  localparam int THR = ((1 << 24) / N) * N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_b = 1'b0, start_s = 1'b0;
  logic        rnd_valid = 1'b0, rd_en = 1'b0;
  logic [31:0] rnd_data = '0;
  logic [6:0]  rd_addr = '0;
  logic        sel = 1'b0;

  logic        b_busy, b_done, b_ready, b_stop;
  logic        s_busy, s_done, s_ready, s_stop;
  logic [14:0] b_loc, s_loc;
`ifdef FW_REJECT_CNT_EN
  logic [15:0] b_rej, s_rej;
`endif

  logic        busy_m, done_m, ready_m, stop_m;
  logic [14:0] loc_m;
  assign busy_m  = sel ? s_busy  : b_busy;
  assign done_m  = sel ? s_done  : b_done;
  assign ready_m = sel ? s_ready : b_ready;
  assign stop_m  = sel ? s_stop  : b_stop;
  assign loc_m   = sel ? s_loc   : b_loc;

  always #5 clk = ~clk;

  fw_loc_sampler #(.N(N), .M(15), .WEIGHT(WB), .LOG_WEIGHT(7)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(b_busy), .done(b_done),
    .rnd_valid(rnd_valid), .rnd_ready(b_ready), .rnd_data(rnd_data), .rnd_stop(b_stop),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_loc(b_loc)
`ifdef FW_REJECT_CNT_EN
    , .rej_cnt(b_rej)
`endif
  );

  fw_loc_sampler #(.N(N), .M(15), .WEIGHT(WS), .LOG_WEIGHT(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(s_busy), .done(s_done),
    .rnd_valid(rnd_valid), .rnd_ready(s_ready), .rnd_data(rnd_data), .rnd_stop(s_stop),
    .rd_en(rd_en), .rd_addr(rd_addr[1:0]), .rd_loc(s_loc)
`ifdef FW_REJECT_CNT_EN
    , .rej_cnt(s_rej)
`endif
  );

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int rej_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // reference model: threshold reject, reduce mod N, drop duplicates, stop when full
  task automatic model(input logic [31:0] w[$], input int ww);
    exp_q.delete();
    rej_exp = 0;
    foreach (w[i]) begin
      int  c;
      int  l;
      bit  d;
      if (exp_q.size() == ww) break;
      c = int'(w[i][23:0]);
      if (c >= THR) begin
        rej_exp++;
      end else begin
        l = c % N;
        d = 1'b0;
        foreach (exp_q[j]) if (exp_q[j] == l) d = 1'b1;
        if (d) rej_exp++;
        else   exp_q.push_back(l);
      end
    end
  endtask

  task automatic pulse(input bit s);
    if (s) start_s = 1'b1;
    else   start_b = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    start_b = 1'b0;
  endtask

  // drives words at negedges; optional 1/0 valid toggling; bounded by budget edges
  task automatic feed(input logic [31:0] w[$], input bit tog, input int budget,
                      output bit got_done, output int cyc);
    int          idx;
    bit          ph;
    bit          acc;
    logic [23:0] c;
    idx = 0; ph = 1'b1; got_done = 1'b0; cyc = 0;
    while (!got_done && cyc < budget) begin
      rnd_valid = (idx < w.size()) && (!tog || ph);
      rnd_data  = (idx < w.size()) ? w[idx] : 32'h0;
      acc = rnd_valid && ready_m;
      c   = rnd_data[23:0];
      @(posedge clk);
      cyc++;
      if (acc) idx++;
      @(negedge clk);
      if (acc && int'(c) < THR) chk("ready_low_in_reduce", {31'b0, ready_m}, 32'd0);
      got_done = done_m;
      ph = !ph;
    end
    rnd_valid = 1'b0;
  endtask

  task automatic end_pulse(input string tag);
    chk({tag, "_stop_with_done"}, {31'b0, stop_m}, 32'd1);
    chk({tag, "_busy_low_in_done"}, {31'b0, busy_m}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_single"}, {31'b0, done_m}, 32'd0);
    chk({tag, "_stop_single"}, {31'b0, stop_m}, 32'd0);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      rd_en = 1'b1;
      rd_addr = 7'(k);
      @(posedge clk);
      @(negedge clk);
      rd_en = 1'b0;
      chk($sformatf("%s_loc%0d", tag, k), {17'b0, loc_m}, 32'(exp_q.pop_front()));
      k++;
    end
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] w2[$];
    bit          got;
    int          cyc;

    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'b0, b_busy},  32'd0);
    chk("rst_done",  {31'b0, b_done},  32'd0);
    chk("rst_ready", {31'b0, b_ready}, 32'd0);
    chk("rst_stop",  {31'b0, b_stop},  32'd0);
    chk("rst_loc",   {17'b0, b_loc},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // increasing words 0..74: minimum latency path
    sel = 1'b0;
    w.delete();
    for (int i = 0; i < WB; i++) w.push_back(32'(i));
    model(w, WB);
    pulse(1'b0);
    chk("t1_busy_after_start", {31'b0, busy_m}, 32'd1);
    feed(w, 1'b0, 400, got, cyc);
    chk("t1_done", {31'b0, got}, 32'd1);
    chk("t1_latency", 32'(cyc + 1), 32'(3 * WB + 1));
    end_pulse("t1");
    drain("t1");
    rd_en = 1'b1; rd_addr = 7'd100;
    @(posedge clk); @(negedge clk);
    rd_en = 1'b0;
    chk("t1_rd_oob", {17'b0, loc_m}, 32'd0);

    // WEIGHT=4: threshold and duplicate rejection
    sel = 1'b1;
    w = '{32'h5, 32'h00FF_FFFF, 32'h4505, 32'h450A, 32'h7, 32'h9};
    model(w, WS);
    pulse(1'b1);
    feed(w, 1'b0, 100, got, cyc);
    chk("t2_done", {31'b0, got}, 32'd1);
    end_pulse("t2");
`ifdef FW_REJECT_CNT_EN
    chk("t2_rej_cnt", {16'b0, s_rej}, 32'(rej_exp));
`endif
    drain("t2");

    // toggling valid, upper byte ignored, threshold boundary
    sel = 1'b0;
    w = '{32'hAB00_000C, 32'h00FF_DB89, 32'h00FF_DB88};
    for (int i = 0; i < WB - 2; i++) w.push_back(32'(3000 + i));
    model(w, WB);
    pulse(1'b0);
    feed(w, 1'b1, 1000, got, cyc);
    chk("t3_done", {31'b0, got}, 32'd1);
    end_pulse("t3");
    drain("t3");

    // reset while in CHECK with 40 entries stored
    w.delete();
    for (int i = 0; i < WB; i++) w.push_back(32'(1000 + i));
    pulse(1'b0);
    feed(w, 1'b0, 3 * 40 + 2, got, cyc);
    chk("t4_no_done_before_rst", {31'b0, got}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy",  {31'b0, busy_m},  32'd0);
    chk("t4_rst_done",  {31'b0, done_m},  32'd0);
    chk("t4_rst_ready", {31'b0, ready_m}, 32'd0);
    chk("t4_rst_stop",  {31'b0, stop_m},  32'd0);
    chk("t4_rst_loc",   {17'b0, loc_m},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rnd_valid = 1'b1; rnd_data = 32'd77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_idle_no_done",  {31'b0, done_m},  32'd0);
      chk("t4_idle_no_ready", {31'b0, ready_m}, 32'd0);
    end
    rnd_valid = 1'b0;
    rd_en = 1'b1; rd_addr = 7'd0;
    @(posedge clk); @(negedge clk);
    rd_en = 1'b0;
    chk("t4_entry0_cleared", {17'b0, loc_m}, 32'd0);
    w.delete();
    for (int i = 0; i < WB; i++) w.push_back(32'(2000 + i));
    model(w, WB);
    pulse(1'b0);
    feed(w, 1'b0, 400, got, cyc);
    chk("t4_done", {31'b0, got}, 32'd1);
    end_pulse("t4");
    drain("t4");

    // start pulse while busy must not restart the vector
    w.delete(); w2.delete();
    for (int i = 0; i < WB; i++) begin
      if (i < 10) w.push_back(32'(5000 + i));
      else        w2.push_back(32'(5000 + i));
    end
    model({w, w2}, WB);
    pulse(1'b0);
    feed(w, 1'b0, 30, got, cyc);
    chk("t5_no_early_done", {31'b0, got}, 32'd0);
    pulse(1'b0);
    feed(w2, 1'b0, 400, got, cyc);
    chk("t5_done", {31'b0, got}, 32'd1);
    chk("t5_remaining_latency", 32'(cyc), 32'(3 * (WB - 10)));
    end_pulse("t5");
    drain("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
